// File: rtl/dvp_tx_pkg.sv
// Shared DVP transmit definitions: frame FSM states, pixel payload and byte order.
// The capture side imports BYTE_HI_FIRST so both ends agree on byte order.
package dvp_tx_pkg;

    localparam int unsigned PIX_W  = 16;
    localparam int unsigned BYTE_W = 8;

    // High byte [15:8] goes on the wire first.
    localparam bit BYTE_HI_FIRST = 1'b1;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        VSYNC  = 3'd1,
        VBACK  = 3'd2,
        ACTIVE = 3'd3,
        VFRONT = 3'd4
    } dvp_state_e;

    typedef struct packed {
        logic [4:0] r;
        logic [5:0] g;
        logic [4:0] b;
    } rgb565_t;

    function automatic logic [BYTE_W-1:0] first_byte(input rgb565_t pix);
        logic [PIX_W-1:0] raw;
        raw = pix;
        return BYTE_HI_FIRST ? raw[15:8] : raw[7:0];
    endfunction

    function automatic logic [BYTE_W-1:0] second_byte(input rgb565_t pix);
        logic [PIX_W-1:0] raw;
        raw = pix;
        return BYTE_HI_FIRST ? raw[7:0] : raw[15:8];
    endfunction

endpackage

// File: rtl/dvp_timing_gen.sv
// Frame timing for the DVP transmitter: pclk phase, slot/line counters and frame FSM.
// Counters and state always describe the slot that will be launched at the next launch edge.
module dvp_timing_gen
    import dvp_tx_pkg::*;
#(
    parameter int unsigned H_ACTIVE = 640,
    parameter int unsigned V_ACTIVE = 480,
    parameter int unsigned H_BLANK  = 144,
    parameter int unsigned VS_LINES = 3,
    parameter int unsigned VB_LINES = 17,
    parameter int unsigned VF_LINES = 10
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    output logic phase,
    output logic launch_c,
    output logic href_c,
    output logic vsync_c,
    output logic need_pix_c,
    output logic low_byte_c,
    output logic first_pix_c,
    output logic frame_done_c
);

    localparam int unsigned LINE_SLOTS = 2 * H_ACTIVE + H_BLANK;
    localparam int unsigned SLOT_W     = $clog2(LINE_SLOTS);
    localparam int unsigned MAX_A      = (V_ACTIVE > VS_LINES) ? V_ACTIVE : VS_LINES;
    localparam int unsigned MAX_B      = (VB_LINES > VF_LINES) ? VB_LINES : VF_LINES;
    localparam int unsigned LINE_MAX   = (MAX_A > MAX_B) ? MAX_A : MAX_B;
    localparam int unsigned LINE_W     = $clog2(LINE_MAX + 1);

    dvp_state_e        state, state_n;
    logic [SLOT_W-1:0] slot, slot_n;
    logic [LINE_W-1:0] line, line_n;
    logic [LINE_W-1:0] lines_m1;

    always_ff @(posedge clk) begin
        if (rst) begin
            phase <= 1'b0;
            state <= IDLE;
            slot  <= '0;
            line  <= '0;
        end else begin
            phase <= ~phase;
            state <= state_n;
            slot  <= slot_n;
            line  <= line_n;
        end
    end

    // Next-state: counters advance only on launch; state moves at line-period boundaries.
    always_comb begin
        state_n      = state;
        slot_n       = slot;
        line_n       = line;
        frame_done_c = 1'b0;
        lines_m1     = '0;

        case (state)
            VSYNC:   lines_m1 = LINE_W'(VS_LINES - 1);
            VBACK:   lines_m1 = LINE_W'(VB_LINES - 1);
            ACTIVE:  lines_m1 = LINE_W'(V_ACTIVE - 1);
            VFRONT:  lines_m1 = LINE_W'(VF_LINES - 1);
            default: lines_m1 = '0;
        endcase

        if (phase) begin
            if (state == IDLE) begin
                if (en) begin
                    state_n = VSYNC;
                    slot_n  = '0;
                    line_n  = '0;
                end
            end else if (slot == SLOT_W'(LINE_SLOTS - 1)) begin
                slot_n = '0;
                if (line == lines_m1) begin
                    line_n = '0;
                    case (state)
                        VSYNC:  state_n = VBACK;
                        VBACK:  state_n = ACTIVE;
                        ACTIVE: state_n = VFRONT;
                        VFRONT: begin
                            state_n      = en ? VSYNC : IDLE;
                            frame_done_c = 1'b1;
                        end
                        default: state_n = IDLE;
                    endcase
                end else begin
                    line_n = line + LINE_W'(1);
                end
            end else begin
                slot_n = slot + SLOT_W'(1);
            end
        end
    end

    assign launch_c    = phase;
    assign href_c      = (state == ACTIVE) && (slot < SLOT_W'(2 * H_ACTIVE));
    assign vsync_c     = (state == VSYNC);
    assign need_pix_c  = href_c && !slot[0];
    assign low_byte_c  = href_c && slot[0];
    assign first_pix_c = (state == ACTIVE) && (slot == '0) && (line == '0);

endmodule

// File: rtl/dvp_pixel_tx.sv
// OV-style DVP camera emulator: RGB565 valid/ready stream in, pclk/href/vsync/byte out.
// Handles the pixel handshake, byte sequencing, underflow fill, SOF checking and frame count.
module dvp_pixel_tx
    import dvp_tx_pkg::*;
#(
    parameter int unsigned H_ACTIVE   = 640,
    parameter int unsigned V_ACTIVE   = 480,
    parameter int unsigned H_BLANK    = 144,
    parameter int unsigned VS_LINES   = 3,
    parameter int unsigned VB_LINES   = 17,
    parameter int unsigned VF_LINES   = 10,
    parameter logic [15:0] FILL_PIXEL = 16'h0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_en,
    input  logic [15:0] s_data,
    input  logic        s_sof,
    input  logic        s_valid,
    output logic        s_ready,
    output logic        o_pclk,
    output logic [7:0]  o_data,
    output logic        o_href,
    output logic        o_vsync,
    output logic        o_underflow,
    output logic        o_sof_err,
    output logic [15:0] o_frame_cnt
);

    logic phase;
    logic launch_c;
    logic href_c;
    logic vsync_c;
    logic need_pix_c;
    logic low_byte_c;
    logic first_pix_c;
    logic frame_done_c;

    rgb565_t           pix_c;
    logic [BYTE_W-1:0] low_byte;

    dvp_timing_gen #(
        .H_ACTIVE (H_ACTIVE),
        .V_ACTIVE (V_ACTIVE),
        .H_BLANK  (H_BLANK),
        .VS_LINES (VS_LINES),
        .VB_LINES (VB_LINES),
        .VF_LINES (VF_LINES)
    ) u_timing (
        .clk          (clk),
        .rst          (rst),
        .en           (i_en),
        .phase        (phase),
        .launch_c     (launch_c),
        .href_c       (href_c),
        .vsync_c      (vsync_c),
        .need_pix_c   (need_pix_c),
        .low_byte_c   (low_byte_c),
        .first_pix_c  (first_pix_c),
        .frame_done_c (frame_done_c)
    );

    assign o_pclk = phase;

    // Pixel sent in a high-byte slot: the stream pixel, or the fill pattern on underflow.
    always_comb begin
        pix_c = rgb565_t'(FILL_PIXEL);
        if (s_valid) begin
            pix_c = rgb565_t'(s_data);
        end
    end

    // s_ready is raised one clk ahead so it is high exactly during the high-byte launch clk.
    always_ff @(posedge clk) begin
        if (rst) begin
            s_ready     <= 1'b0;
            o_data      <= '0;
            o_href      <= 1'b0;
            o_vsync     <= 1'b0;
            o_underflow <= 1'b0;
            o_sof_err   <= 1'b0;
            o_frame_cnt <= '0;
            low_byte    <= '0;
        end else begin
            o_sof_err <= 1'b0;
            s_ready   <= !launch_c && need_pix_c;
            if (launch_c) begin
                o_href  <= href_c;
                o_vsync <= vsync_c;
                if (need_pix_c) begin
                    o_data   <= first_byte(pix_c);
                    low_byte <= second_byte(pix_c);
                    if (!s_valid) begin
                        o_underflow <= 1'b1;
                    end else if (s_sof != first_pix_c) begin
                        o_sof_err <= 1'b1;
                    end
                end else if (low_byte_c) begin
                    o_data <= low_byte;
                end else begin
                    o_data <= '0;
                end
                if (frame_done_c) begin
                    o_frame_cnt <= o_frame_cnt + 16'd1;
                end
            end
        end
    end

endmodule

// File: tb/tb_dvp_pixel_tx.sv
// Directed bench for dvp_pixel_tx with a small frame (L=14 slots, frame=140 clk).
module tb_dvp_pixel_tx;

    localparam int unsigned H_ACTIVE = 4;
    localparam int unsigned V_ACTIVE = 2;
    localparam int unsigned H_BLANK  = 6;
    localparam int unsigned VS_LINES = 1;
    localparam int unsigned VB_LINES = 1;
    localparam int unsigned VF_LINES = 1;

    logic        clk = 1'b0;
    logic        rst;
    logic        i_en;
    logic [15:0] s_data;
    logic        s_sof;
    logic        s_valid;
    logic        s_ready;
    logic        o_pclk;
    logic [7:0]  o_data;
    logic        o_href;
    logic        o_vsync;
    logic        o_underflow;
    logic        o_sof_err;
    logic [15:0] o_frame_cnt;

    always #5 clk = ~clk;

    dvp_pixel_tx #(
        .H_ACTIVE   (H_ACTIVE),
        .V_ACTIVE   (V_ACTIVE),
        .H_BLANK    (H_BLANK),
        .VS_LINES   (VS_LINES),
        .VB_LINES   (VB_LINES),
        .VF_LINES   (VF_LINES),
        .FILL_PIXEL (16'h0)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .i_en        (i_en),
        .s_data      (s_data),
        .s_sof       (s_sof),
        .s_valid     (s_valid),
        .s_ready     (s_ready),
        .o_pclk      (o_pclk),
        .o_data      (o_data),
        .o_href      (o_href),
        .o_vsync     (o_vsync),
        .o_underflow (o_underflow),
        .o_sof_err   (o_sof_err),
        .o_frame_cnt (o_frame_cnt)
    );

    logic [15:0] pix_tab [32] = '{
        16'hA1B2, 16'hC3D4, 16'hE5F6, 16'h0718, 16'h293A, 16'h4B5C, 16'h6D7E, 16'h8F90,
        16'h1122, 16'h3344, 16'h5566, 16'h7788, 16'h99AA, 16'hBBCC, 16'hDDEE,
        16'hF011, 16'hF122, 16'hF233, 16'hF344, 16'hF455, 16'hF566, 16'hF677, 16'hF788,
        16'h1234, 16'h1234, 16'h1234, 16'h1234, 16'h1234, 16'h1234, 16'h1234, 16'h1234,
        16'h1234
    };

    // Frame 2 has a fill pixel in its 3rd slot pair; frame 3 carries the SOF error pixel.
    logic [7:0] exp_bytes [48] = '{
        8'hA1, 8'hB2, 8'hC3, 8'hD4, 8'hE5, 8'hF6, 8'h07, 8'h18,
        8'h29, 8'h3A, 8'h4B, 8'h5C, 8'h6D, 8'h7E, 8'h8F, 8'h90,
        8'h11, 8'h22, 8'h33, 8'h44, 8'h00, 8'h00, 8'h55, 8'h66,
        8'h77, 8'h88, 8'h99, 8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'hEE,
        8'hF0, 8'h11, 8'hF1, 8'h22, 8'hF2, 8'h33, 8'hF3, 8'h44,
        8'hF4, 8'h55, 8'hF5, 8'h66, 8'hF6, 8'h77, 8'hF7, 8'h88
    };

    int checks = 0;
    int errors = 0;

    int cyc = 0;
    int pix_idx = 0;
    int pif = 0;
    int frame_no = 0;
    int rises = 0;
    int vs_run = 0;
    int href_run = 0;
    int sof_clks = 0;
    int sof_run = 0;
    int sof_max = 0;
    bit dropped = 1'b0;
    logic prev_vs = 1'b0;
    logic prev_href = 1'b0;
    int vs_w [$];
    int href_w [$];
    int rise_t [$];
    logic [7:0] bytes_q [$];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // One clk: observe outputs at the falling edge, then drive the pixel source.
    task automatic tick();
        bit hs;
        hs = s_ready && s_valid;
        @(posedge clk);
        @(negedge clk);
        cyc++;
        if (hs) begin
            pix_idx++;
            pif++;
        end
        if (o_vsync && !prev_vs) begin
            rises++;
            frame_no++;
            pif = 0;
            rise_t.push_back(cyc);
        end
        if (o_vsync) vs_run++;
        else if (prev_vs) begin
            vs_w.push_back(vs_run);
            vs_run = 0;
        end
        if (o_href) href_run++;
        else if (prev_href) begin
            href_w.push_back(href_run);
            href_run = 0;
        end
        if (o_href && !o_pclk) bytes_q.push_back(o_data);
        if (o_sof_err) begin
            sof_clks++;
            sof_run++;
            if (sof_run > sof_max) sof_max = sof_run;
        end else begin
            sof_run = 0;
        end
        prev_vs   = o_vsync;
        prev_href = o_href;

        s_data = pix_tab[pix_idx % 32];
        s_sof  = (pif == 0) || (frame_no == 3 && pif == 1);
        if (s_ready && frame_no == 2 && pif == 2 && !dropped) begin
            s_valid = 1'b0;
            dropped = 1'b1;
        end else begin
            s_valid = 1'b1;
        end
    endtask

    task automatic wait_rises(input int n, input int budget, input string tag);
        int k;
        k = 0;
        while (rises < n && k < budget) begin
            tick();
            k++;
        end
        check(tag, rises, n);
    endtask

    task automatic wait_href(input int budget, input string tag);
        int k;
        k = 0;
        while (!o_href && k < budget) begin
            tick();
            k++;
        end
        check(tag, {31'd0, o_href}, 1);
    endtask

    initial begin
        rst     = 1'b1;
        i_en    = 1'b0;
        s_data  = pix_tab[0];
        s_sof   = 1'b1;
        s_valid = 1'b1;
        repeat (3) tick();
        check("rst_pclk", {31'd0, o_pclk}, 0);
        check("rst_sigs", {28'd0, o_href, o_vsync, o_underflow, o_sof_err}, 0);
        check("rst_data", {24'd0, o_data}, 0);
        check("rst_fcnt", {16'd0, o_frame_cnt}, 0);
        check("rst_ready", {31'd0, s_ready}, 0);

        rst = 1'b0;
        check("pclk_0", {31'd0, o_pclk}, 0);
        tick();
        check("pclk_1", {31'd0, o_pclk}, 1);
        tick();
        check("pclk_2", {31'd0, o_pclk}, 0);
        tick();
        check("pclk_3", {31'd0, o_pclk}, 1);
        check("idle_href", {31'd0, o_href | o_vsync}, 0);

        i_en = 1'b1;
        wait_rises(1, 40, "vsync_rise1");
        check("fcnt_f1", {16'd0, o_frame_cnt}, 0);
        wait_rises(2, 200, "vsync_rise2");
        check("fcnt_f2", {16'd0, o_frame_cnt}, 1);
        check("uflow_f1", {31'd0, o_underflow}, 0);
        check("sof_f1", sof_clks, 0);
        wait_rises(3, 200, "vsync_rise3");
        check("fcnt_f3", {16'd0, o_frame_cnt}, 2);
        check("uflow_f2", {31'd0, o_underflow}, 1);
        check("sof_f2", sof_clks, 0);

        wait_href(100, "f3_href");
        i_en = 1'b0;
        repeat (400) tick();
        check("no_more_vsync", rises, 3);
        check("fcnt_end", {16'd0, o_frame_cnt}, 3);
        check("sof_clks", sof_clks, 1);
        check("sof_width", sof_max, 1);
        check("idle_out", {29'd0, o_href, o_vsync, s_ready}, 0);
        check("uflow_sticky", {31'd0, o_underflow}, 1);

        for (int i = 0; i < 3; i++)
            check($sformatf("vs_width%0d", i), (i < vs_w.size()) ? vs_w[i] : -1, 28);
        for (int i = 0; i < 6; i++)
            check($sformatf("href_width%0d", i), (i < href_w.size()) ? href_w[i] : -1, 16);
        for (int i = 1; i < 3; i++)
            check($sformatf("frame_len%0d", i),
                  (i < rise_t.size()) ? rise_t[i] - rise_t[i-1] : -1, 140);
        check("byte_count", bytes_q.size(), 48);
        for (int i = 0; i < 48; i++)
            check($sformatf("byte%0d", i),
                  (i < bytes_q.size()) ? {24'd0, bytes_q[i]} : 32'hFFFF_FFFF,
                  {24'd0, exp_bytes[i]});

        i_en = 1'b1;
        wait_href(300, "f4_href");
        rst = 1'b1;
        tick();
        check("mrst_href", {31'd0, o_href}, 0);
        check("mrst_vsync", {31'd0, o_vsync}, 0);
        check("mrst_data", {24'd0, o_data}, 0);
        check("mrst_ready", {31'd0, s_ready}, 0);
        check("mrst_fcnt", {16'd0, o_frame_cnt}, 0);
        check("mrst_uflow", {31'd0, o_underflow}, 0);
        check("mrst_pclk", {31'd0, o_pclk}, 0);
        tick();
        check("mrst_hold", {30'd0, o_vsync, o_href}, 0);
        rst  = 1'b0;
        i_en = 1'b0;
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
